// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and defaults for the pipeline hazard controller
package pipe_ctrl_pkg;
  localparam int STATE_W = 2;
  localparam int MC_TIMEOUT_DEF = 64;
  typedef enum logic [STATE_W-1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MC_BUSY    = 2'd2
  } state_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds the instruction in ID
module load_use_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memRead,
  output logic       hazard
);
  assign hazard = ex_memRead & id_valid & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: central stall/flush FSM for the five-stage pipeline
module pipeline_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_redirect,
  input  logic             ex_mc_start,
  input  logic             mc_done,
  output logic             pcWrite,
  output logic             IF_ID_write_en,
  output logic             ID_EX_write_en,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             ex_hold,
  output logic             mc_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  state_t     cur, nxt;
  logic [7:0] mc_cnt;
  logic       hazard, busy, in_run, mc_expire, mc_hold, redirect_ok, mc_take, lu_take, hold;

  load_use_detect u_lud (
    .id_valid  (id_valid),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .ex_rd     (ex_rd),
    .ex_memRead(ex_memRead),
    .hazard    (hazard)
  );

  // the unused encoding falls into the RUN decode
  always_comb begin
    busy           = cur == MC_BUSY;
    in_run         = ~busy & (cur != LOAD_STALL);
    mc_expire      = busy & ~mc_done & (mc_cnt == 8'(MC_TIMEOUT - 1));
    mc_hold        = busy & ~mc_done & ~mc_expire;
    redirect_ok    = ~busy & ex_redirect;
    mc_take        = in_run & ~ex_redirect & ex_mc_start;
    lu_take        = in_run & ~ex_redirect & ~ex_mc_start & hazard;
    hold           = mc_take | mc_hold;
    pcWrite        = ~rst & ~hold & ~lu_take;
    IF_ID_write_en = ~rst & ~hold & ~lu_take;
    ID_EX_write_en = ~rst & ~hold;
    ID_EX_bubble   = rst | lu_take;
    IF_ID_flush    = ~rst & redirect_ok;
    ID_EX_flush    = ~rst & redirect_ok;
    ex_hold        = ~rst & hold;
    nxt            = (mc_take | mc_hold) ? MC_BUSY : lu_take ? LOAD_STALL : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur          <= RUN;
      mc_cnt       <= '0;
      mc_timeout   <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      cur    <= nxt;
      mc_cnt <= mc_take ? 8'd0 : mc_hold ? mc_cnt + 8'd1 : mc_cnt;
      if (mc_expire) mc_timeout <= 1'b1;
      if (~pcWrite && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (redirect_ok && flush_events != '1) flush_events <= flush_events + 1'b1;
    end
  end

  assign state = cur;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed scenario checks for the hazard controller
module tb_pipeline_hazard_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, ex_memRead, ex_redirect, ex_mc_start, mc_start_t, mc_done;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        pcWrite, IF_ID_write_en, ID_EX_write_en, ID_EX_bubble, IF_ID_flush, ID_EX_flush, ex_hold, mc_timeout;
  logic [1:0]  state;
  logic [31:0] stall_cycles, flush_events;
  logic        t_pcWrite, t_ifid_we, t_idex_we, t_bubble, t_ifid_fl, t_idex_fl, t_ex_hold, t_mc_timeout;
  logic [1:0]  t_state;
  logic [31:0] t_stall, t_flush;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memRead(ex_memRead), .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
    .pcWrite(pcWrite), .IF_ID_write_en(IF_ID_write_en), .ID_EX_write_en(ID_EX_write_en),
    .ID_EX_bubble(ID_EX_bubble), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .ex_hold(ex_hold), .mc_timeout(mc_timeout), .state(state),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipeline_hazard_controller #(.MC_TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memRead(ex_memRead), .ex_redirect(ex_redirect), .ex_mc_start(mc_start_t), .mc_done(mc_done),
    .pcWrite(t_pcWrite), .IF_ID_write_en(t_ifid_we), .ID_EX_write_en(t_idex_we),
    .ID_EX_bubble(t_bubble), .IF_ID_flush(t_ifid_fl), .ID_EX_flush(t_idex_fl),
    .ex_hold(t_ex_hold), .mc_timeout(t_mc_timeout), .state(t_state),
    .stall_cycles(t_stall), .flush_events(t_flush)
  );

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_memRead = 0;
    ex_redirect = 0; ex_mc_start = 0; mc_start_t = 0; mc_done = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    #2;
    checks++; if (pcWrite !== 1'b0 || ID_EX_write_en !== 1'b0 || IF_ID_write_en !== 1'b0) begin errors++; $display("FAIL rst_enables got %b%b%b exp 000", pcWrite, IF_ID_write_en, ID_EX_write_en); end
    checks++; if (ID_EX_bubble !== 1'b1 || ex_hold !== 1'b0 || IF_ID_flush !== 1'b0 || ID_EX_flush !== 1'b0) begin errors++; $display("FAIL rst_bubble got bub=%b hold=%b fl=%b%b exp 1 0 00", ID_EX_bubble, ex_hold, IF_ID_flush, ID_EX_flush); end
    step();
    rst = 0;
    #1;
    checks++; if (state !== 2'd0 || stall_cycles !== 32'd0 || flush_events !== 32'd0 || mc_timeout !== 1'b0) begin errors++; $display("FAIL rst_state got st=%0d stall=%0d flush=%0d to=%b exp 0 0 0 0", state, stall_cycles, flush_events, mc_timeout); end
    checks++; if ({pcWrite, IF_ID_write_en, ID_EX_write_en, ID_EX_bubble, IF_ID_flush, ID_EX_flush, ex_hold} !== 7'b1110000) begin errors++; $display("FAIL run_default got %b exp 1110000", {pcWrite, IF_ID_write_en, ID_EX_write_en, ID_EX_bubble, IF_ID_flush, ID_EX_flush, ex_hold}); end
  endtask

  task automatic test_load_use();
    id_valid = 1; ex_memRead = 1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
    #1;
    checks++; if ({pcWrite, IF_ID_write_en, ID_EX_write_en, ID_EX_bubble, ex_hold} !== 5'b00110) begin errors++; $display("FAIL lu_stall got %b exp 00110", {pcWrite, IF_ID_write_en, ID_EX_write_en, ID_EX_bubble, ex_hold}); end
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL lu_state got %0d exp 1", state); end
    checks++; if (pcWrite !== 1'b1 || ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL lu_suppressed got pc=%b bub=%b exp 1 0", pcWrite, ID_EX_bubble); end
    idle();
    step();
    checks++; if (state !== 2'd0 || stall_cycles !== 32'd1) begin errors++; $display("FAIL lu_done got st=%0d stall=%0d exp 0 1", state, stall_cycles); end
  endtask

  task automatic test_x0();
    id_valid = 1; ex_memRead = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd9;
    #1;
    checks++; if (pcWrite !== 1'b1 || ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL x0_nostall got pc=%b bub=%b exp 1 0", pcWrite, ID_EX_bubble); end
    ex_rd = 5'd9; id_valid = 0;
    #1;
    checks++; if (pcWrite !== 1'b1) begin errors++; $display("FAIL invalid_nostall got pc=%b exp 1", pcWrite); end
    step();
    checks++; if (state !== 2'd0 || stall_cycles !== 32'd1) begin errors++; $display("FAIL x0_state got st=%0d stall=%0d exp 0 1", state, stall_cycles); end
    idle();
  endtask

  task automatic test_redirect_priority();
    id_valid = 1; ex_memRead = 1; ex_rd = 5'd7; id_rs1 = 5'd7; ex_redirect = 1;
    #1;
    checks++; if ({pcWrite, IF_ID_write_en, ID_EX_write_en, ID_EX_bubble, IF_ID_flush, ID_EX_flush, ex_hold} !== 7'b1110110) begin errors++; $display("FAIL redir_outs got %b exp 1110110", {pcWrite, IF_ID_write_en, ID_EX_write_en, ID_EX_bubble, IF_ID_flush, ID_EX_flush, ex_hold}); end
    step();
    idle();
    #1;
    checks++; if (state !== 2'd0 || flush_events !== 32'd1 || stall_cycles !== 32'd1) begin errors++; $display("FAIL redir_cnt got st=%0d fl=%0d stall=%0d exp 0 1 1", state, flush_events, stall_cycles); end
  endtask

  task automatic test_mc();
    ex_mc_start = 1; mc_done = 1;
    #1;
    checks++; if ({pcWrite, IF_ID_write_en, ID_EX_write_en, ex_hold} !== 4'b0001) begin errors++; $display("FAIL mc_entry got %b exp 0001", {pcWrite, IF_ID_write_en, ID_EX_write_en, ex_hold}); end
    step();
    ex_mc_start = 0; mc_done = 0; ex_redirect = 1;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL mc_state got %0d exp 2", state); end
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (ex_hold !== 1'b1 || pcWrite !== 1'b0 || IF_ID_flush !== 1'b0) begin errors++; $display("FAIL mc_busy%0d got hold=%b pc=%b fl=%b exp 1 0 0", i, ex_hold, pcWrite, IF_ID_flush); end
      step();
    end
    ex_redirect = 0; mc_done = 1;
    #1;
    checks++; if ({pcWrite, IF_ID_write_en, ID_EX_write_en, ex_hold} !== 4'b1110) begin errors++; $display("FAIL mc_release got %b exp 1110", {pcWrite, IF_ID_write_en, ID_EX_write_en, ex_hold}); end
    step();
    idle();
    checks++; if (state !== 2'd0 || stall_cycles !== 32'd7 || flush_events !== 32'd1 || mc_timeout !== 1'b0) begin errors++; $display("FAIL mc_after got st=%0d stall=%0d fl=%0d to=%b exp 0 7 1 0", state, stall_cycles, flush_events, mc_timeout); end
  endtask

  task automatic test_timeout();
    mc_start_t = 1;
    #1;
    checks++; if (t_ex_hold !== 1'b1) begin errors++; $display("FAIL to_entry got hold=%b exp 1", t_ex_hold); end
    step();
    mc_start_t = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (t_ex_hold !== (k < 3) || t_pcWrite !== (k == 3) || t_mc_timeout !== 1'b0) begin errors++; $display("FAIL to_cycle%0d got hold=%b pc=%b to=%b", k, t_ex_hold, t_pcWrite, t_mc_timeout); end
      step();
    end
    checks++; if (t_state !== 2'd0 || t_mc_timeout !== 1'b1) begin errors++; $display("FAIL to_set got st=%0d to=%b exp 0 1", t_state, t_mc_timeout); end
    step(); step();
    checks++; if (t_mc_timeout !== 1'b1 || mc_timeout !== 1'b0) begin errors++; $display("FAIL to_sticky got t=%b main=%b exp 1 0", t_mc_timeout, mc_timeout); end
  endtask

  task automatic test_rst_mid_busy();
    ex_mc_start = 1;
    step();
    ex_mc_start = 0;
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rmb_busy got %0d exp 2", state); end
    rst = 1;
    #1;
    checks++; if (pcWrite !== 1'b0 || ID_EX_bubble !== 1'b1 || ex_hold !== 1'b0) begin errors++; $display("FAIL rmb_rst got pc=%b bub=%b hold=%b exp 0 1 0", pcWrite, ID_EX_bubble, ex_hold); end
    step();
    rst = 0;
    checks++; if (state !== 2'd0 || stall_cycles !== 32'd0 || flush_events !== 32'd0 || t_mc_timeout !== 1'b0) begin errors++; $display("FAIL rmb_clear got st=%0d stall=%0d fl=%0d to=%b exp 0 0 0 0", state, stall_cycles, flush_events, t_mc_timeout); end
    mc_done = 1;
    #1;
    checks++; if (pcWrite !== 1'b1 || ex_hold !== 1'b0) begin errors++; $display("FAIL rmb_late_done got pc=%b hold=%b exp 1 0", pcWrite, ex_hold); end
    step();
    mc_done = 0;
    checks++; if (state !== 2'd0 || mc_timeout !== 1'b0 || stall_cycles !== 32'd0) begin errors++; $display("FAIL rmb_after got st=%0d to=%b stall=%0d exp 0 0 0", state, mc_timeout, stall_cycles); end
  endtask

  task automatic test_back_to_back();
    id_valid = 1; ex_memRead = 1; ex_rd = 5'd12; id_rs1 = 5'd12;
    #1;
    checks++; if (pcWrite !== 1'b0) begin errors++; $display("FAIL b2b_first got pc=%b exp 0", pcWrite); end
    step();
    checks++; if (pcWrite !== 1'b1 || state !== 2'd1) begin errors++; $display("FAIL b2b_gap got pc=%b st=%0d exp 1 1", pcWrite, state); end
    step();
    checks++; if (pcWrite !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL b2b_second got pc=%b st=%0d exp 0 0", pcWrite, state); end
    step();
    ex_redirect = 1;
    #1;
    checks++; if (state !== 2'd1 || IF_ID_flush !== 1'b1 || ID_EX_flush !== 1'b1 || ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL b2b_redir got st=%0d fl=%b%b bub=%b exp 1 11 0", state, IF_ID_flush, ID_EX_flush, ID_EX_bubble); end
    step();
    idle();
    checks++; if (state !== 2'd0 || stall_cycles !== 32'd2 || flush_events !== 32'd1) begin errors++; $display("FAIL b2b_cnt got st=%0d stall=%0d fl=%0d exp 0 2 1", state, stall_cycles, flush_events); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_redirect_priority();
    test_mc();
    test_timeout();
    test_rst_mid_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage RV32I pipeline. Replaces per-stage ad-hoc hazard gating with one FSM that decides, every cycle, whether PC, IF/ID and ID/EX advance, hold, bubble or flush. Inputs come from the decode stage (source registers), EX (destination, load flag, redirect, multi-cycle op) and a multi-cycle execute unit (divider). Outputs drive the PC register, IF/ID and ID/EX pipeline registers and EX hold. Saturating performance counters are exposed for debug.

## Interface
- MC_TIMEOUT, 64: maximum MC_BUSY cycles before forced abort (2..255).
- CNT_W, 32: width of performance counters.
- clk  in  1  rising-edge clock; one clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- ex_rd  in  5  destination of the instruction in EX.
- ex_memRead  in  1  EX instruction is a load.
- ex_redirect  in  1  EX resolved a taken branch, jal or jalr.
- ex_mc_start  in  1  EX holds a multi-cycle op needing the unit.
- mc_done  in  1  multi-cycle unit result valid (one-cycle pulse).
- pcWrite  out  1  PC may update.
- IF_ID_write_en  out  1  IF/ID may load.
- ID_EX_write_en  out  1  ID/EX may load.
- ID_EX_bubble  out  1  force ID control signals to zero into ID/EX.
- IF_ID_flush, ID_EX_flush  out  1  clear the respective register next edge.
- ex_hold  out  1  freeze EX/MEM and the EX operands.
- mc_timeout  out  1  sticky error: multi-cycle op aborted.
- state  out  2  current FSM state (debug).
- stall_cycles  out  CNT_W  cycles with pcWrite=0 after reset.
- flush_events  out  CNT_W  number of accepted redirects.

## Operation
- States: RUN=0, LOAD_STALL=1, MC_BUSY=2. Encoding 3 unused; if reached, behaves as RUN and next state is RUN.
- Outputs are combinational from current state and inputs; state, timeout counter, error and perf counters are registered.
- Default (RUN, no event): pcWrite=1, IF_ID_write_en=1, ID_EX_write_en=1, all others 0.
- Load-use hazard: ex_memRead & id_valid & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Priority in RUN: ex_redirect > ex_mc_start > load-use.
- RUN + ex_redirect: IF_ID_flush=1, ID_EX_flush=1, enables 1; flush_events+1; stay RUN.
- RUN + ex_mc_start: pcWrite=0, IF_ID_write_en=0, ID_EX_write_en=0, ex_hold=1; clear timeout counter; next MC_BUSY.
- RUN + load-use: pcWrite=0, IF_ID_write_en=0, ID_EX_bubble=1; next LOAD_STALL.
- LOAD_STALL: default outputs, hazard check suppressed; ex_redirect honoured as in RUN; next RUN. Stall is exactly one cycle.
- MC_BUSY, mc_done=0: same holds as entry; counter+1; ex_redirect and ex_mc_start ignored.
- MC_BUSY, mc_done=1: holds released (default outputs) in this cycle; next RUN.
- MC_BUSY, counter==MC_TIMEOUT-1 without mc_done: release as with mc_done, set mc_timeout, next RUN.
- Counters saturate at all-ones; stall_cycles increments in any non-reset cycle with pcWrite=0.

## Timing
- Reset: while rst=1, pcWrite=IF_ID_write_en=ID_EX_write_en=0, ID_EX_bubble=1, flushes=0, ex_hold=0. After the edge: state=RUN, counters=0, mc_timeout=0, timeout counter=0.
- rst mid-MC_BUSY: returns to RUN next edge; mc_done arriving later in RUN is ignored.
- Zero-cycle decision latency; one-edge state latency.
- Load-use costs 1 bubble; multi-cycle op costs N+1 held cycles for mc_done at N cycles after entry.
- mc_done coinciding with entry cycle (RUN) is ignored; the unit must take at least one cycle.

## Structure
- Package pipe_ctrl_pkg: state enum (RUN, LOAD_STALL, MC_BUSY), state width, default MC_TIMEOUT.
- Sub-module load_use_detect: combinational hazard compare (id_valid, rs1, rs2, ex_rd, ex_memRead → hazard).
- Top holds FSM, timeout counter, error flag, perf counters.

## Test plan
- Load x5 in EX, ID uses rs2=x5 → one cycle pcWrite=0, bubble=1; next cycle RUN defaults; stall_cycles=1.
- Load to x0 with id_rs1=0 → no stall, state stays RUN.
- ex_redirect and load-use same cycle → both flushes=1, pcWrite=1, no bubble; flush_events=1.
- ex_mc_start, mc_done 5 cycles later → 6 cycles holds/ex_hold=1, release on done cycle; stall_cycles=6.
- MC_TIMEOUT=4, no mc_done → release on 4th MC_BUSY cycle, mc_timeout=1 sticky until rst.
- rst asserted in MC_BUSY → state RUN, counters 0, late mc_done ignored.
